// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-port controller for the 32x32 integer register file.
// After reset it runs a clear sweep that writes INIT_VALUE to x1..x(NREGS-1),
// then round-robin arbitrates the ALU (port 0) and load/multicycle (port 1)
// writeback requesters onto the single register file write port.
// Optional macro RFARB_FWD_EN adds same-cycle write forwarding for rs1/rs2.
module regfile_wb_arbiter #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 5,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_write_register,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              init_busy,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam logic [0:0]        ST_INIT    = 1'b0;
    localparam logic [0:0]        ST_RUN     = 1'b1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_addr;
    logic              last_grant;
    logic              run;
    logic              grant0;
    logic              grant1;

    // Grants are only possible in RUN outside reset; on a tie the port that
    // did not win last time is chosen, so neither requester waits twice.
    always_comb begin
        run    = (state == ST_RUN) && !reset;
        grant0 = run && req0_valid && (!req1_valid || last_grant);
        grant1 = run && req1_valid && (!req0_valid || !last_grant);
    end

    // Sweep address, state and round-robin history; the sweep stops at the
    // top register without wrapping and hands over to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            init_addr  <= FIRST_ADDR;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_addr == LAST_ADDR) begin
                        state <= ST_RUN;
                    end else begin
                        init_addr <= init_addr + FIRST_ADDR;
                    end
                end
                default: begin
                    if (grant0) begin
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        last_grant <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Write port mux: sweep writes during INIT, granted request in RUN.
    // A granted x0 write is consumed but never asserts reg_write.
    always_comb begin
        rf_reg_write      = 1'b0;
        rf_write_register = '0;
        rf_write_data     = '0;
        req0_ready        = grant0;
        req1_ready        = grant1;
        init_busy         = reset || (state == ST_INIT);
        if (!reset) begin
            if (state == ST_INIT) begin
                rf_reg_write      = 1'b1;
                rf_write_register = init_addr;
                rf_write_data     = INIT_VALUE;
            end else if (grant0) begin
                rf_reg_write      = (req0_rd != '0);
                rf_write_register = req0_rd;
                rf_write_data     = req0_data;
            end else if (grant1) begin
                rf_reg_write      = (req1_rd != '0);
                rf_write_register = req1_rd;
                rf_write_data     = req1_data;
            end
        end
    end

`ifdef RFARB_FWD_EN
    // Same-cycle forwarding of the write being committed, RUN only.
    always_comb begin
        fwd_data = rf_write_data;
        fwd1_hit = run && rf_reg_write && (rs1 == rf_write_register) && (rs1 != '0);
        fwd2_hit = run && rf_reg_write && (rs2 == rf_write_register) && (rs2 != '0);
    end
`else
    logic unused_rs;

    // Forwarding disabled: outputs tied low, read addresses ignored.
    always_comb begin
        fwd_data  = '0;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        unused_rs = ^{rs1, rs2};
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: init sweep, mid-sweep reset, directed
// vector table for arbitration / x0 writes, and a randomized run against a
// behavioural model with a register file image.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        rf_reg_write;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic        init_busy;
    logic [4:0]  rs1, rs2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    logic [31:0] model_rf [32];

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [8];

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd(req1_rd), .req1_data(req1_data),
        .rf_reg_write(rf_reg_write), .rf_write_register(rf_write_register),
        .rf_write_data(rf_write_data), .init_busy(init_busy),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Register file stand-in: x0 is hard zero, everything else starts dirty.
    always @(posedge clk) begin
        if (rf_reg_write && rf_write_register != 5'd0)
            mem[rf_write_register] <= rf_write_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst,
                                 input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        reset      = rst;
        req0_valid = v0;  req0_rd = rd0;  req0_data = d0;
        req1_valid = v1;  req1_rd = rd1;  req1_data = d1;
        #2;
    endtask

    task automatic checkFwd(input string tag, input logic exp_we, input logic [4:0] exp_wa,
                            input logic [31:0] exp_wd, input logic in_run);
        logic h1, h2;
        logic [31:0] fd;
`ifdef RFARB_FWD_EN
        h1 = in_run && exp_we && rs1 == exp_wa && rs1 != 5'd0;
        h2 = in_run && exp_we && rs2 == exp_wa && rs2 != 5'd0;
        fd = exp_wd;
`else
        h1 = 1'b0;
        h2 = 1'b0;
        fd = 32'd0;
`endif
        checkOutput({tag, " fwd1_hit"}, {31'd0, fwd1_hit}, {31'd0, h1});
        checkOutput({tag, " fwd2_hit"}, {31'd0, fwd2_hit}, {31'd0, h2});
        if (in_run)
            checkOutput({tag, " fwd_data"}, fwd_data, fd);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h5555_5555, 1'b1, 5'd8, 32'h6666_6666);
        checkOutput("reset rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("reset ready0", {31'd0, req0_ready}, 32'd0);
        checkOutput("reset ready1", {31'd0, req1_ready}, 32'd0);
        checkOutput("reset init_busy", {31'd0, init_busy}, 32'd1);
    endtask

    // Expect sweep writes to addresses 1..upto, requesters valid but ignored.
    task automatic checkSweep(input int upto);
        for (int k = 1; k <= upto; k++) begin
            rs1 = 5'(k);
            rs2 = 5'd0;
            applyStimulus(1'b0, 1'b1, 5'(k), 32'h1234, 1'b1, 5'd2, 32'h9999);
            checkOutput($sformatf("sweep%0d we", k), {31'd0, rf_reg_write}, 32'd1);
            checkOutput($sformatf("sweep%0d addr", k), {27'd0, rf_write_register}, k);
            checkOutput($sformatf("sweep%0d data", k), rf_write_data, 32'd0);
            checkOutput($sformatf("sweep%0d busy", k), {31'd0, init_busy}, 32'd1);
            checkOutput($sformatf("sweep%0d readys", k), {30'd0, req1_ready, req0_ready}, 32'd0);
            checkFwd($sformatf("sweep%0d", k), 1'b0, 5'd0, 32'd0, 1'b0);
        end
    endtask

    task automatic idleAfterSweep(input string tag);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput({tag, " busy low"}, {31'd0, init_busy}, 32'd0);
        checkOutput({tag, " idle we"}, {31'd0, rf_reg_write}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0;
        rs1 = 0; rs2 = 0;
        mem[0] = 32'd0;
        for (int i = 1; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;

        vecs[0] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11};
        vecs[1] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22};
        vecs[2] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11};
        vecs[3] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22};
        vecs[4] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd9, 32'h77, 1, 0, 1, 5'd5, 32'hDEADBEEF};
        vecs[5] = '{0, 5'd6, 32'h88, 1, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 5'd0, 32'hFFFFFFFF};
        vecs[6] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11};
        vecs[7] = '{0, 5'd3, 32'h11, 0, 5'd4, 32'h22, 0, 0, 0, 5'd0, 32'h0};

        $display("[TB] init sweep");
        doReset();
        checkSweep(31);
        idleAfterSweep("sweep");
        for (int i = 1; i < 32; i++)
            checkOutput($sformatf("clear x%0d", i), mem[i], 32'd0);

        $display("[TB] reset mid-sweep");
        doReset();
        checkSweep(9);
        doReset();
        checkSweep(31);
        idleAfterSweep("restart");

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            rs1 = vecs[i].wa;
            rs2 = 5'd0;
            applyStimulus(1'b0, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1);
            checkOutput($sformatf("vec%0d ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
            checkOutput($sformatf("vec%0d ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
            checkOutput($sformatf("vec%0d we", i), {31'd0, rf_reg_write}, {31'd0, vecs[i].we});
            checkOutput($sformatf("vec%0d addr", i), {27'd0, rf_write_register}, {27'd0, vecs[i].wa});
            checkOutput($sformatf("vec%0d data", i), rf_write_data, vecs[i].wd);
            checkFwd($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b1);
        end
        checkOutput("x5 readback", mem[5], 32'hDEADBEEF);
        checkOutput("x3 readback", mem[3], 32'h11);
        checkOutput("x4 readback", mem[4], 32'h22);
        checkOutput("x0 readback", mem[0], 32'd0);

        $display("[TB] randomized run");
        doReset();
        checkSweep(31);
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        begin
            logic        v0, v1, hold0, hold1, lg, g0, g1, ewe;
            logic [4:0]  rd0, rd1, ewa;
            logic [31:0] d0, d1, ewd;
            int          wait0, wait1;
            lg = 1'b1;
            hold0 = 0; hold1 = 0;
            wait0 = 0; wait1 = 0;
            v0 = 0; v1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
            for (int c = 0; c < 400; c++) begin
                if (!hold0) begin
                    v0 = ($urandom % 4) != 0;
                    rd0 = 5'($urandom_range(0, 31));
                    d0 = $urandom;
                end
                if (!hold1) begin
                    v1 = ($urandom % 4) != 0;
                    rd1 = 5'($urandom_range(0, 31));
                    d1 = $urandom;
                end
                rs1 = ($urandom % 2) ? rd0 : 5'($urandom_range(0, 31));
                rs2 = ($urandom % 2) ? rd1 : 5'($urandom_range(0, 31));
                // Tie goes to whichever port was not served most recently.
                if (v0 && v1) begin
                    g0 = (lg == 1'b1);
                    g1 = !g0;
                end else begin
                    g0 = v0;
                    g1 = v1;
                end
                ewe = 0; ewa = 0; ewd = 0;
                if (g0) begin ewa = rd0; ewd = d0; ewe = (rd0 != 0); end
                if (g1) begin ewa = rd1; ewd = d1; ewe = (rd1 != 0); end
                applyStimulus(1'b0, v0, rd0, d0, v1, rd1, d1);
                checkOutput($sformatf("rnd%0d ready0", c), {31'd0, req0_ready}, {31'd0, g0});
                checkOutput($sformatf("rnd%0d ready1", c), {31'd0, req1_ready}, {31'd0, g1});
                checkOutput($sformatf("rnd%0d we", c), {31'd0, rf_reg_write}, {31'd0, ewe});
                checkOutput($sformatf("rnd%0d addr", c), {27'd0, rf_write_register}, {27'd0, ewa});
                checkOutput($sformatf("rnd%0d data", c), rf_write_data, ewd);
                checkFwd($sformatf("rnd%0d", c), ewe, ewa, ewd, 1'b1);
                if (g0) lg = 1'b0;
                if (g1) lg = 1'b1;
                if (ewe) model_rf[ewa] = ewd;
                hold0 = v0 && !g0;
                hold1 = v1 && !g1;
                wait0 = hold0 ? wait0 + 1 : 0;
                wait1 = hold1 ? wait1 + 1 : 0;
                if (wait0 > 1 || wait1 > 1)
                    checkOutput($sformatf("rnd%0d starvation", c), wait0 > wait1 ? wait0 : wait1, 32'd1);
            end
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            for (int i = 0; i < 32; i++)
                checkOutput($sformatf("final x%0d", i), mem[i], model_rf[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
